// File: rtl/i2s_rx_core.sv
// i2s_rx_core: slave-mode I2S receiver.
//
// Oversamples an externally driven I2S bus (i2s_sck, i2s_ws, i2s_sd) in the
// clk domain. It deserialises MSB-first words with the standard one-bit
// word-select delay and stores them in separate left and right show-ahead
// FIFOs. The status outputs line up with the SR_reg fields of the APB wrapper.
//
// Parameters
//   DATA_WIDTH  bits per stored word (2..32)
//   FIFO_DEPTH  entries per channel FIFO (power of 2, >= 2)
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   i2s_enable            receiver enable; low forces the FSM to IDLE
//   fifo_clr              1-cycle pulse: empty both FIFOs, clear overrun
//   i2s_sck/ws/sd         asynchronous bus inputs from the external master
//   rd_en_l, rd_data_l    left FIFO pop / head word
//   rd_en_r, rd_data_r    right FIFO pop / head word
//   fifol_full/empty      left FIFO status
//   fifor_full/empty      right FIFO status
//   i2s_rx_done           1-cycle pulse when a right word is written
//   overrun               sticky: a word was dropped on a full FIFO
//   ovr_cnt               dropped-word counter (saturates at 255). This port
//                         exists only when I2S_RX_OVR_CNT_EN is defined.
//
// Read interface: rd_data_x always shows the head entry while the FIFO is
// not empty, and is 0 while it is empty. Pulsing rd_en_x for one cycle
// consumes the head entry. The next entry is visible the following cycle.
// A rd_en_x pulse on an empty FIFO is ignored.

module i2s_rx_core #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2s_enable,
  input  logic                  fifo_clr,
  input  logic                  i2s_sck,
  input  logic                  i2s_ws,
  input  logic                  i2s_sd,
  input  logic                  rd_en_l,
  output logic [DATA_WIDTH-1:0] rd_data_l,
  input  logic                  rd_en_r,
  output logic [DATA_WIDTH-1:0] rd_data_r,
  output logic                  fifol_full,
  output logic                  fifol_empty,
  output logic                  fifor_full,
  output logic                  fifor_empty,
  output logic                  i2s_rx_done,
  output logic                  overrun
`ifdef I2S_RX_OVR_CNT_EN
  ,
  output logic [7:0]            ovr_cnt
`endif
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DW_C   = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] DW_M1  = CW'(DATA_WIDTH - 1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  // ---------------------------------------------------------------------
  // Input synchronisers. All three inputs share the same latency, so ws and
  // sd stay aligned with the detected sck rising edge.
  // ---------------------------------------------------------------------
  logic sck_m, sck_s, sck_d;
  logic ws_m, ws_s;
  logic sd_m, sd_s;
  logic sck_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_m <= 1'b0; sck_s <= 1'b0; sck_d <= 1'b0;
      ws_m  <= 1'b0; ws_s  <= 1'b0;
      sd_m  <= 1'b0; sd_s  <= 1'b0;
    end else begin
      sck_m <= i2s_sck; sck_s <= sck_m; sck_d <= sck_s;
      ws_m  <= i2s_ws;  ws_s  <= ws_m;
      sd_m  <= i2s_sd;  sd_s  <= sd_m;
    end
  end

  assign sck_rise = sck_s & ~sck_d;

  // ---------------------------------------------------------------------
  // Deserialiser FSM
  // ---------------------------------------------------------------------
  state_t                  state;
  logic                    ws_last;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [DATA_WIDTH-1:0]   shreg_next;
  logic [CW-1:0]           bitcnt;
  logic [CW-1:0]           bitcnt_next;
  logic                    commit_vld;
  logic                    commit_ch;    // 0 = left, 1 = right
  logic [DATA_WIDTH-1:0]   commit_word;

  // The shift register is cleared at every word start, so OR-ing the bit into
  // its slot is enough. Bits past DATA_WIDTH are dropped, and unfilled LSBs
  // stay 0.
  always_comb begin
    shreg_next  = shreg;
    bitcnt_next = bitcnt;
    if (bitcnt < DW_C) begin
      shreg_next  = shreg | ({{(DATA_WIDTH-1){1'b0}}, sd_s} << (DW_M1 - bitcnt));
      bitcnt_next = bitcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ws_last     <= 1'b0;
      shreg       <= '0;
      bitcnt      <= '0;
      commit_vld  <= 1'b0;
      commit_ch   <= 1'b0;
      commit_word <= '0;
      i2s_rx_done <= 1'b0;
    end else begin
      commit_vld  <= 1'b0;
      i2s_rx_done <= 1'b0;
      if (!i2s_enable) begin
        // Drop any partial word. While idle, ws_last follows the bus so that
        // enabling mid-word waits for the next genuine ws edge.
        state   <= IDLE;
        shreg   <= '0;
        bitcnt  <= '0;
        ws_last <= ws_s;
      end else begin
        case (state)
          IDLE: begin
            state   <= SYNC;
            ws_last <= ws_s;
          end
          SYNC: begin
            if (sck_rise) begin
              ws_last <= ws_s;
              if (ws_s != ws_last) begin
                state  <= RUN;
                shreg  <= '0;
                bitcnt <= '0;
              end
            end
          end
          RUN: begin
            if (sck_rise) begin
              if (ws_s != ws_last) begin
                // A ws edge marks the LSB of the current word, because ws
                // leads the data by one bit. Commit the word to the channel
                // it was received on.
                commit_vld  <= 1'b1;
                commit_ch   <= ws_last;
                commit_word <= shreg_next;
                i2s_rx_done <= ws_last;
                shreg       <= '0;
                bitcnt      <= '0;
                ws_last     <= ws_s;
              end else begin
                shreg  <= shreg_next;
                bitcnt <= bitcnt_next;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Channel FIFOs (index 0 = left, 1 = right)
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [0:1][0:FIFO_DEPTH-1];
  logic [PW-1:0]         wp  [0:1];
  logic [PW-1:0]         rp  [0:1];
  logic [PW:0]           cnt [0:1];
  logic [1:0]            full, empty, wr, rd_req, do_wr, do_rd, drop;

  always_comb begin
    rd_req = {rd_en_r, rd_en_l};
    wr     = {commit_vld & commit_ch, commit_vld & ~commit_ch};
    full   = '0;
    empty  = '0;
    do_wr  = '0;
    do_rd  = '0;
    drop   = '0;
    for (int ch = 0; ch < 2; ch++) begin
      full[ch]  = (cnt[ch] == CNT_FULL);
      empty[ch] = (cnt[ch] == '0);
      do_rd[ch] = rd_req[ch] & ~empty[ch];
      // When the FIFO is full, a write still goes in if the same cycle
      // frees a slot.
      do_wr[ch] = wr[ch] & (~full[ch] | rd_req[ch]);
      drop[ch]  = wr[ch] & full[ch] & ~rd_req[ch];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || fifo_clr) begin
      for (int ch = 0; ch < 2; ch++) begin
        wp[ch]  <= '0;
        rp[ch]  <= '0;
        cnt[ch] <= '0;
      end
      overrun <= 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (do_wr[ch]) wp[ch] <= wp[ch] + 1'b1;
        if (do_rd[ch]) rp[ch] <= rp[ch] + 1'b1;
        if (do_wr[ch] && !do_rd[ch])      cnt[ch] <= cnt[ch] + 1'b1;
        else if (!do_wr[ch] && do_rd[ch]) cnt[ch] <= cnt[ch] - 1'b1;
      end
      if (|drop) overrun <= 1'b1;
    end
  end

  // Storage carries no reset. Reads are masked with empty, so stale entries
  // are never visible.
  always_ff @(posedge clk) begin
    if (!rst && !fifo_clr) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (do_wr[ch]) mem[ch][wp[ch]] <= commit_word;
      end
    end
  end

  assign rd_data_l   = empty[0] ? '0 : mem[0][rp[0]];
  assign rd_data_r   = empty[1] ? '0 : mem[1][rp[1]];
  assign fifol_full  = full[0];
  assign fifol_empty = empty[0];
  assign fifor_full  = full[1];
  assign fifor_empty = empty[1];

`ifdef I2S_RX_OVR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || fifo_clr) begin
      ovr_cnt <= 8'd0;
    end else if ((|drop) && (ovr_cnt != 8'hFF)) begin
      ovr_cnt <= ovr_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx_core.sv
// Testbench for i2s_rx_core. It drives the I2S bus as an external master
// (sck = clk/8, ws/sd change while sck is low) and predicts FIFO contents with
// queue-based channel models.
module tb_i2s_rx_core;
  localparam int DW = 32;
  localparam int FD = 8;

  logic clk = 1'b0;
  logic rst, i2s_enable, fifo_clr, i2s_sck, i2s_ws, i2s_sd, rd_en_l, rd_en_r;
  logic [DW-1:0] rd_data_l, rd_data_r;
  logic fifol_full, fifol_empty, fifor_full, fifor_empty, i2s_rx_done, overrun;
`ifdef I2S_RX_OVR_CNT_EN
  logic [7:0] ovr_cnt;
`endif

  i2s_rx_core #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .i2s_enable(i2s_enable), .fifo_clr(fifo_clr),
    .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .rd_en_l(rd_en_l), .rd_data_l(rd_data_l), .rd_en_r(rd_en_r), .rd_data_r(rd_data_r),
    .fifol_full(fifol_full), .fifol_empty(fifol_empty),
    .fifor_full(fifor_full), .fifor_empty(fifor_empty),
    .i2s_rx_done(i2s_rx_done), .overrun(overrun)
`ifdef I2S_RX_OVR_CNT_EN
    , .ovr_cnt(ovr_cnt)
`endif
  );

  // clock / bookkeeping
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  always @(posedge clk) if (i2s_rx_done === 1'b1) done_cnt <= done_cnt + 1;

  // scoreboard: expected channel FIFO contents
  logic [DW-1:0] exp_l[$];
  logic [DW-1:0] exp_r[$];
  logic model_ovr;
  int   model_drops;
  int   toggle_bit;
  logic toggle_val;

  // Word as it should be stored: truncated to its MSBs or zero-padded.
  function automatic logic [DW-1:0] fit(input logic [63:0] data, input int slot);
    logic [63:0] v;
    v = data & ((64'd1 << slot) - 64'd1);
    if (slot >= DW) v = v >> (slot - DW);
    else            v = v << (DW - slot);
    return v[DW-1:0];
  endfunction

  task automatic model_commit(input logic ch, input logic [63:0] data, input int slot,
                              input logic popped);
    logic [DW-1:0] w;
    w = fit(data, slot);
    if (ch == 1'b0) begin
      if (exp_l.size() == FD) begin
        if (popped) begin void'(exp_l.pop_front()); exp_l.push_back(w); end
        else begin model_ovr = 1'b1; model_drops++; end
      end else exp_l.push_back(w);
    end else begin
      if (exp_r.size() == FD) begin
        if (popped) begin void'(exp_r.pop_front()); exp_r.push_back(w); end
        else begin model_ovr = 1'b1; model_drops++; end
      end else exp_r.push_back(w);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sck period. With pop set, rd_en_l is pulsed in the clk cycle where
  // the word finishing on this bit reaches the FIFO.
  task automatic drive_bit(input logic w, input logic d, input logic pop);
    i2s_sck = 1'b0; i2s_ws = w; i2s_sd = d;
    tick(4);
    i2s_sck = 1'b1;
    if (pop) begin tick(3); rd_en_l = 1'b1; tick(1); rd_en_l = 1'b0; end
    else tick(4);
  endtask

  // ws switches to next_ch on the LSB (one-bit I2S delay).
  task automatic send_word(input logic [63:0] data, input int slot, input logic ch,
                           input logic next_ch, input logic pop);
    for (int k = 0; k < slot; k++) begin
      if (k == toggle_bit) i2s_enable = toggle_val;
      drive_bit((k == slot - 1) ? next_ch : ch, data[slot-1-k], pop && (k == slot - 1));
    end
  endtask

  task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int slot,
                            input logic cap_l, input logic cap_r);
    send_word(l, slot, 1'b0, 1'b1, 1'b0);
    if (cap_l) model_commit(1'b0, l, slot, 1'b0);
    send_word(r, slot, 1'b1, 1'b0, 1'b0);
    if (cap_r) model_commit(1'b1, r, slot, 1'b0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    rst = 1'b1; i2s_enable = 1'b0; fifo_clr = 1'b0;
    i2s_sck = 1'b0; i2s_ws = 1'b1; i2s_sd = 1'b0; rd_en_l = 1'b0; rd_en_r = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    exp_l.delete(); exp_r.delete();
    model_ovr = 1'b0; model_drops = 0; toggle_bit = -1; toggle_val = 1'b0;
  endtask

  // Enable, then present a ws edge (end of a notional right word) to sync on.
  task automatic start();
    i2s_enable = 1'b1;
    tick(2);
    drive_bit(1'b0, 1'b0, 1'b0);
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1; tick(3);
    tests_run++; if (rd_data_l !== '0) begin tests_failed++; $display("FAIL reset_rd_data_l got=%h exp=0", rd_data_l); end
    tests_run++; if (rd_data_r !== '0) begin tests_failed++; $display("FAIL reset_rd_data_r got=%h exp=0", rd_data_r); end
    tests_run++; if ({fifol_empty, fifor_empty, fifol_full, fifor_full} !== 4'b1100) begin
      tests_failed++; $display("FAIL reset_flags got=%b exp=1100", {fifol_empty, fifor_empty, fifol_full, fifor_full}); end
    tests_run++; if ({i2s_rx_done, overrun} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_done_ovr got=%b exp=00", {i2s_rx_done, overrun}); end
    do_reset();
  endtask

  task automatic test_basic();
    int d0;
    do_reset(); start();
    d0 = done_cnt;
    send_frame(64'hA5A5_0001, 64'h5A5A_0002, 32, 1'b1, 1'b1);
    tick(12);
    tests_run++; if (rd_data_l !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL basic_left got=%h exp=a5a50001", rd_data_l); end
    tests_run++; if (rd_data_r !== 32'h5A5A_0002) begin tests_failed++; $display("FAIL basic_right got=%h exp=5a5a0002", rd_data_r); end
    tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
    tests_run++; if ({fifol_empty, fifor_empty} !== 2'b00) begin tests_failed++; $display("FAIL basic_not_empty got=%b exp=00", {fifol_empty, fifor_empty}); end
  endtask

  task automatic test_mid_enable();
    logic [63:0] l1, r1;
    do_reset();
    i2s_ws = 1'b0; tick(4);
    l1 = rnd64(); r1 = rnd64();
    toggle_bit = 12; toggle_val = 1'b1;
    send_word(l1, 32, 1'b0, 1'b1, 1'b0);
    toggle_bit = -1;
    send_word(r1, 32, 1'b1, 1'b0, 1'b0);
    model_commit(1'b1, r1, 32, 1'b0);
    tick(12);
    tests_run++; if (fifol_empty !== 1'b1) begin tests_failed++; $display("FAIL midena_no_partial got=%b exp=1", fifol_empty); end
    tests_run++; if (rd_data_r !== fit(r1, 32)) begin tests_failed++; $display("FAIL midena_first_right got=%h exp=%h", rd_data_r, fit(r1, 32)); end
    send_frame(rnd64(), rnd64(), 32, 1'b1, 1'b1);
    tick(12);
    while (exp_l.size() > 0) begin
      tests_run++; if (rd_data_l !== exp_l[0]) begin tests_failed++; $display("FAIL midena_drain_l got=%h exp=%h", rd_data_l, exp_l[0]); end
      void'(exp_l.pop_front()); rd_en_l = 1'b1; tick(1); rd_en_l = 1'b0;
    end
    while (exp_r.size() > 0) begin
      tests_run++; if (rd_data_r !== exp_r[0]) begin tests_failed++; $display("FAIL midena_drain_r got=%h exp=%h", rd_data_r, exp_r[0]); end
      void'(exp_r.pop_front()); rd_en_r = 1'b1; tick(1); rd_en_r = 1'b0;
    end
    tests_run++; if ({fifol_empty, fifor_empty} !== 2'b11) begin tests_failed++; $display("FAIL midena_empty got=%b exp=11", {fifol_empty, fifor_empty}); end
  endtask

  task automatic test_slot_len();
    do_reset(); start();
    send_frame(64'hAB_CDEF, rnd64(), 24, 1'b1, 1'b1);
    send_frame({24'h0, 32'h1234_5678, 8'($urandom())}, rnd64(), 40, 1'b1, 1'b1);
    tick(12);
    tests_run++; if (rd_data_l !== 32'hABCD_EF00) begin tests_failed++; $display("FAIL slot24_left got=%h exp=abcdef00", rd_data_l); end
    rd_en_l = 1'b1; tick(1); rd_en_l = 1'b0;
    tests_run++; if (rd_data_l !== 32'h1234_5678) begin tests_failed++; $display("FAIL slot40_left got=%h exp=12345678", rd_data_l); end
    rd_en_l = 1'b1; tick(1); rd_en_l = 1'b0;
    while (exp_r.size() > 0) begin
      tests_run++; if (rd_data_r !== exp_r[0]) begin tests_failed++; $display("FAIL slot_drain_r got=%h exp=%h", rd_data_r, exp_r[0]); end
      void'(exp_r.pop_front()); rd_en_r = 1'b1; tick(1); rd_en_r = 1'b0;
    end
    tests_run++; if ({fifol_empty, fifor_empty} !== 2'b11) begin tests_failed++; $display("FAIL slot_empty got=%b exp=11", {fifol_empty, fifor_empty}); end
  endtask

  task automatic test_overrun();
    do_reset(); start();
    for (int f = 0; f < FD + 1; f++) send_frame(rnd64(), rnd64(), 32, 1'b1, 1'b1);
    tick(12);
    tests_run++; if ({fifol_full, fifor_full} !== 2'b11) begin tests_failed++; $display("FAIL ovr_full got=%b exp=11", {fifol_full, fifor_full}); end
    tests_run++; if (overrun !== model_ovr) begin tests_failed++; $display("FAIL ovr_flag got=%b exp=%b", overrun, model_ovr); end
    tests_run++; if (rd_data_l !== exp_l[0]) begin tests_failed++; $display("FAIL ovr_head_l got=%h exp=%h", rd_data_l, exp_l[0]); end
    tests_run++; if (rd_data_r !== exp_r[0]) begin tests_failed++; $display("FAIL ovr_head_r got=%h exp=%h", rd_data_r, exp_r[0]); end
`ifdef I2S_RX_OVR_CNT_EN
    tests_run++; if (ovr_cnt !== 8'(model_drops)) begin tests_failed++; $display("FAIL ovr_cnt got=%0d exp=%0d", ovr_cnt, model_drops); end
`endif
    fifo_clr = 1'b1; tick(1); fifo_clr = 1'b0; tick(1);
    exp_l.delete(); exp_r.delete(); model_ovr = 1'b0; model_drops = 0;
    tests_run++; if ({fifol_empty, fifor_empty, fifol_full, fifor_full} !== 4'b1100) begin
      tests_failed++; $display("FAIL clr_flags got=%b exp=1100", {fifol_empty, fifor_empty, fifol_full, fifor_full}); end
    tests_run++; if (overrun !== model_ovr) begin tests_failed++; $display("FAIL clr_overrun got=%b exp=%b", overrun, model_ovr); end
`ifdef I2S_RX_OVR_CNT_EN
    tests_run++; if (ovr_cnt !== 8'd0) begin tests_failed++; $display("FAIL clr_ovr_cnt got=%0d exp=0", ovr_cnt); end
`endif
  endtask

  task automatic test_full_rw();
    logic [63:0] lnew;
    do_reset(); start();
    for (int f = 0; f < FD; f++) send_frame(rnd64(), rnd64(), 32, 1'b1, 1'b1);
    lnew = rnd64();
    send_word(lnew, 32, 1'b0, 1'b1, 1'b1);
    model_commit(1'b0, lnew, 32, 1'b1);
    tick(12);
    tests_run++; if (fifol_full !== 1'b1) begin tests_failed++; $display("FAIL fullrw_full got=%b exp=1", fifol_full); end
    tests_run++; if (overrun !== model_ovr) begin tests_failed++; $display("FAIL fullrw_overrun got=%b exp=%b", overrun, model_ovr); end
    while (exp_l.size() > 0) begin
      tests_run++; if (rd_data_l !== exp_l[0]) begin tests_failed++; $display("FAIL fullrw_drain_l got=%h exp=%h", rd_data_l, exp_l[0]); end
      void'(exp_l.pop_front()); rd_en_l = 1'b1; tick(1); rd_en_l = 1'b0;
    end
    while (exp_r.size() > 0) begin
      tests_run++; if (rd_data_r !== exp_r[0]) begin tests_failed++; $display("FAIL fullrw_drain_r got=%h exp=%h", rd_data_r, exp_r[0]); end
      void'(exp_r.pop_front()); rd_en_r = 1'b1; tick(1); rd_en_r = 1'b0;
    end
    tests_run++; if ({fifol_empty, fifor_empty} !== 2'b11) begin tests_failed++; $display("FAIL fullrw_empty got=%b exp=11", {fifol_empty, fifor_empty}); end
  endtask

  task automatic test_disable();
    logic [63:0] rb;
    do_reset(); start();
    send_frame(rnd64(), rnd64(), 32, 1'b1, 1'b1);
    send_word(rnd64(), 32, 1'b0, 1'b1, 1'b0);
    model_commit(1'b0, 64'h0, 0, 1'b0);
    void'(exp_l.pop_back());
    toggle_bit = 10; toggle_val = 1'b0;
    rb = rnd64();
    send_word(rb, 32, 1'b1, 1'b0, 1'b0);
    toggle_bit = -1;
    tick(12);
    tests_run++; if (rd_data_r !== exp_r[0]) begin tests_failed++; $display("FAIL dis_right_intact got=%h exp=%h", rd_data_r, exp_r[0]); end
    i2s_enable = 1'b1; tick(2);
    send_frame(rnd64(), rnd64(), 32, 1'b0, 1'b1);
    send_frame(rnd64(), rnd64(), 32, 1'b1, 1'b1);
    tick(12);
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL dis_overrun got=%b exp=0", overrun); end
    while (exp_r.size() > 0) begin
      tests_run++; if (rd_data_r !== exp_r[0]) begin tests_failed++; $display("FAIL dis_drain_r got=%h exp=%h", rd_data_r, exp_r[0]); end
      void'(exp_r.pop_front()); rd_en_r = 1'b1; tick(1); rd_en_r = 1'b0;
    end
    tests_run++; if (fifor_empty !== 1'b1) begin tests_failed++; $display("FAIL dis_r_empty got=%b exp=1", fifor_empty); end
  endtask

  task automatic test_random();
    int sl, sr;
    logic [63:0] l, r;
    do_reset(); start();
    for (int f = 0; f < 5; f++) begin
      sl = $urandom_range(40, 8); sr = $urandom_range(40, 8);
      l = rnd64(); r = rnd64();
      send_word(l, sl, 1'b0, 1'b1, 1'b0); model_commit(1'b0, l, sl, 1'b0);
      send_word(r, sr, 1'b1, 1'b0, 1'b0); model_commit(1'b1, r, sr, 1'b0);
    end
    tick(12);
    while (exp_l.size() > 0) begin
      tests_run++; if (rd_data_l !== exp_l[0]) begin tests_failed++; $display("FAIL rand_drain_l got=%h exp=%h", rd_data_l, exp_l[0]); end
      void'(exp_l.pop_front()); rd_en_l = 1'b1; tick(1); rd_en_l = 1'b0;
    end
    while (exp_r.size() > 0) begin
      tests_run++; if (rd_data_r !== exp_r[0]) begin tests_failed++; $display("FAIL rand_drain_r got=%h exp=%h", rd_data_r, exp_r[0]); end
      void'(exp_r.pop_front()); rd_en_r = 1'b1; tick(1); rd_en_r = 1'b0;
    end
    tests_run++; if ({fifol_empty, fifor_empty} !== 2'b11) begin tests_failed++; $display("FAIL rand_empty got=%b exp=11", {fifol_empty, fifor_empty}); end
  endtask

  // sequence + final report
  initial begin
    rst = 1'b1; i2s_enable = 1'b0; fifo_clr = 1'b0;
    i2s_sck = 1'b0; i2s_ws = 1'b1; i2s_sd = 1'b0; rd_en_l = 1'b0; rd_en_r = 1'b0;
    toggle_bit = -1; toggle_val = 1'b0; model_ovr = 1'b0; model_drops = 0;
    tick(1);
    test_reset();
    test_basic();
    test_mid_enable();
    test_slot_len();
    test_overrun();
    test_full_rw();
    test_disable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
